// File: rtl/spi_reg_writer.sv
// SPI Mode 0 write-frame initiator: serialises {1, addr[6:0], wdata[7:0]} MSB first.
// Define SPI_READBACK_EN to capture cipo and present the response low byte on rd_data.
`timescale 1ns/1ps
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BITS_LAST  = 5'd16;

  state_t      state;
  logic [7:0]  phase_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        phase_end;

  assign phase_end = (phase_cnt == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= 8'd0;
      bit_cnt   <= 5'd0;
      shift_reg <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
    end else begin
      done      <= 1'b0;
      phase_cnt <= phase_end ? 8'd0 : phase_cnt + 8'd1;
      case (state)
        IDLE: begin
          phase_cnt <= 8'd0;
          if (start) begin
            shift_reg <= {1'b1, addr, wdata};
            state     <= SETUP;
            busy      <= 1'b1;
            ncs       <= 1'b0;
            copi      <= 1'b1;
            bit_cnt   <= 5'd0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            sclk    <= 1'b1;
            bit_cnt <= 5'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            if (sclk) begin
              // Falling edge: present the next bit, except after the last one
              sclk <= 1'b0;
              if (bit_cnt != BITS_LAST) begin
                copi      <= shift_reg[14];
                shift_reg <= {shift_reg[14:0], 1'b0};
              end
            end else if (bit_cnt == BITS_LAST) begin
              state <= HOLD;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= (bit_cnt == BITS_LAST) ? BITS_LAST : bit_cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            ncs   <= 1'b1;
            copi  <= 1'b0;
            done  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (phase_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [15:0] cap_reg;
  logic        sclk_rise;
  logic        frame_end;

  // Mirrors the FSM conditions that drive sclk 0->1 and the done pulse
  assign sclk_rise = phase_end && ((state == SETUP) ||
                     (state == SHIFT && !sclk && bit_cnt != BITS_LAST));
  assign frame_end = phase_end && (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_reg <= 16'd0;
      rd_data <= 8'h00;
    end else begin
      if (sclk_rise)
        cap_reg <= {cap_reg[14:0], cipo};
      if (frame_end)
        rd_data <= cap_reg[7:0];
    end
  end
`else
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign rd_data     = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: Mode-0 target model decodes frames and drives cipo.
`timescale 1ns/1ps
module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       cipo = 1'b0;
  logic       busy, done, sclk, ncs, copi;
  logic [7:0] rd_data;

  spi_reg_writer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Target model: Mode 0, samples copi on sclk rising, drives cipo from ncs fall / sclk fall
  localparam logic [15:0] RESP = 16'h00A5;
  logic [15:0] rx = 16'd0;
  int          nbits = 0;
  int          cidx = 0;
  logic [15:0] frames[$];
  int          fbits[$];

  always @(negedge ncs) begin
    rx = 16'd0;
    nbits = 0;
    cipo = RESP[15];
    cidx = 14;
  end

  always @(negedge sclk) begin
    if (ncs === 1'b0 && cidx >= 0) begin
      cipo = RESP[cidx];
      cidx--;
    end
  end

  always @(posedge sclk) begin
    if (ncs === 1'b0) begin
      rx = {rx[14:0], copi};
      nbits++;
    end
  end

  always @(posedge ncs) begin
    if (nbits > 0) begin
      frames.push_back(rx);
      fbits.push_back(nbits);
      nbits = 0;
    end
  end

  // Per-cycle monitor, sampled on the falling clk edge
  int         low_run = 0, last_low = 0;
  int         busy_run = 0, last_busy = 0;
  int         hi_run = 0, last_hi = 0;
  int         done_cnt = 0;
  logic [7:0] rd_at_done = 8'h00;

  always @(negedge clk) begin
    if (ncs === 1'b0) begin
      low_run++;
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      hi_run++;
    end
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run > 0) last_busy = busy_run;
      busy_run = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      rd_at_done = rd_data;
    end
  end

  task automatic clear_mon();
    frames.delete();
    fbits.delete();
    done_cnt = 0;
    last_hi = 0;
  endtask

  task automatic write(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int ok = 0;
    for (int i = 0; i < 2000 && ok == 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
    end
    if (ok == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [7:0] rd_exp;

  initial begin
`ifdef SPI_READBACK_EN
    rd_exp = 8'hA5;
`else
    rd_exp = 8'h00;
`endif
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 8'h00);

    // Single write 0x84F0
    clear_mon();
    write(7'h04, 8'hF0);
    wait_idle("single");
    repeat (3) @(negedge clk);
    check("single_nframes", frames.size(), 1);
    if (frames.size() > 0) begin
      check("single_frame", frames[0], 16'h84F0);
      check("single_bits", fbits[0], 16);
    end
    check("single_ncs_low", last_low, 136);
    check("single_busy_high", last_busy, 140);
    check("single_done", done_cnt, 1);
    check("single_copi_idle", copi, 0);

    // Start while busy is ignored
    clear_mon();
    write(7'h00, 8'h55);
    repeat (48) @(posedge clk);
    #1 addr = 7'h01; wdata = 8'hAA; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("busy_ign");
    repeat (20) @(negedge clk);
    check("busy_ign_nframes", frames.size(), 1);
    if (frames.size() > 0) check("busy_ign_frame", frames[0], 16'h8055);
    check("busy_ign_done", done_cnt, 1);
    check("busy_ign_idle", busy, 0);

    // Back-to-back with start held
    clear_mon();
    @(posedge clk); #1;
    addr = 7'h00; wdata = 8'h11; start = 1'b1;
    @(posedge clk); #1 wdata = 8'h22;
    begin
      int ok = 0;
      for (int i = 0; i < 2000 && ok == 0; i++) begin
        @(negedge clk);
        if (frames.size() == 1 && ncs === 1'b0) ok = 1;
      end
      if (ok == 0) check("b2b_second_accept_timeout", 32'd0, 32'd1);
    end
    start = 1'b0;
    wait_idle("b2b");
    repeat (3) @(negedge clk);
    check("b2b_nframes", frames.size(), 2);
    if (frames.size() > 1) begin
      check("b2b_frame0", frames[0], 16'h8011);
      check("b2b_frame1", frames[1], 16'h8022);
    end
    check("b2b_gap", last_hi, 5);
    check("b2b_done", done_cnt, 2);

    // Reset after the 8th rising edge
    clear_mon();
    write(7'h7F, 8'h0F);
    begin
      int ok = 0;
      for (int i = 0; i < 2000 && ok == 0; i++) begin
        @(negedge clk);
        if (nbits == 8) ok = 1;
      end
      if (ok == 0) check("midrst_wait_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_ncs", ncs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    repeat (200) @(negedge clk);
    check("midrst_done", done_cnt, 0);
    check("midrst_rd_data", rd_data, 8'h00);
    check("midrst_partial", frames.size(), 1);
    if (frames.size() > 0) check("midrst_partial_bits", fbits[0], 8);

    // Follow-up write decodes correctly; also exercises readback
    clear_mon();
    write(7'h03, 8'h33);
    wait_idle("post_rst");
    repeat (3) @(negedge clk);
    check("post_rst_nframes", frames.size(), 1);
    if (frames.size() > 0) check("post_rst_frame", frames[0], 16'h8333);
    check("post_rst_done", done_cnt, 1);
    check("readback_at_done", rd_at_done, rd_exp);
    repeat (20) @(negedge clk);
    check("readback_hold", rd_data, rd_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
